// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mips_pkg;

  // R-type functcodes routed to the HI/LO unit
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // Two's-complement magnitude. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shift-add multiplier or restoring divider.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
// Ports: is_div selects divide; acc_i is the {upper,lower} working register;
//        opnd_i is the multiplicand or divisor magnitude; acc_o is the next
//        working register (quotient bit slot left 0); q_bit_o is the new
//        quotient bit (0 for multiply).
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opnd_i,
  output logic [2*W-1:0] acc_o,
  output logic           q_bit_o
);

  logic [W:0] sum;
  logic [W:0] trial;
  logic [W:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Add the multiplicand when the multiplier LSB is set, then shift the
    // carry-extended sum right into the product.
    sum   = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: acc = {remainder, remaining dividend/quotient bits}.
    // The remainder is always below the divisor, so the shifted trial fits
    // in W+1 bits and diff[W] is a clean borrow flag.
    trial = {acc_i[2*W-1:W], acc_i[W-1]};
    diff  = trial - {1'b0, opnd_i};

    acc_o   = '0;
    q_bit_o = 1'b0;
    if (is_div) begin
      q_bit_o = ~diff[W];
      acc_o   = {(diff[W] ? trial[W-1:0] : diff[W-1:0]), acc_i[W-2:0], 1'b0};
    end else begin
      acc_o   = {sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Latency: accept at E0, 32 RUN edges, HI/LO written with done at E33.
// Backpressure: req_ready only in IDLE; requester holds inputs while low.
// Ports: req_valid/req_ready handshake with functcode, rs_content,
//        rt_content; cancel aborts an in-flight op or drops an IDLE request;
//        busy = op in flight; done = one-cycle pulse after HI/LO update.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            functcode,
  input  logic [DATA_WIDTH-1:0] rs_content,
  input  logic [DATA_WIDTH-1:0] rt_content,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  muldiv_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   rs_q, rs_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;        // negate product / quotient
  logic           rem_neg_q, rem_neg_d;
  logic           dz_q, dz_d;          // divide by zero
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic [2*W-1:0] step_acc;
  logic           step_q_bit;
  logic           op_signed;
  logic           op_div;
  logic [W-1:0]   mag_rs;
  logic [W-1:0]   mag_rt;

  muldiv_step #(.W(W)) u_step (
    .is_div  (is_div_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rs_d      = rs_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    op_signed = (functcode == FUNCT_MULT) || (functcode == FUNCT_DIV);
    op_div    = (functcode == FUNCT_DIV)  || (functcode == FUNCT_DIVU);
    mag_rs    = op_signed ? abs32(rs_content) : rs_content;
    mag_rt    = op_signed ? abs32(rt_content) : rt_content;

    case (state_q)
      IDLE: begin
        if (req_valid && !cancel) begin
          case (functcode)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
              state_d   = RUN;
              cnt_d     = '0;
              is_div_d  = op_div;
              neg_d     = op_signed && (rs_content[W-1] ^ rt_content[W-1]);
              rem_neg_d = op_signed && rs_content[W-1];
              dz_d      = (rt_content == '0);
              rs_d      = rs_content;
              // Divide keeps the dividend in the low half; multiply keeps
              // the multiplier there and adds the multiplicand on top.
              acc_d     = {{W{1'b0}}, op_div ? mag_rs : mag_rt};
              opnd_d    = op_div ? mag_rt : mag_rs;
            end
            FUNCT_MTHI: hi_d = rs_content;
            FUNCT_MTLO: lo_d = rs_content;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc | {{(2*W-1){1'b0}}, step_q_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_q ? (~acc_q + 1'b1) : acc_q;
          end else if (dz_q) begin
            lo_d = '1;
            hi_d = rs_q;
          end else begin
            lo_d = neg_q     ? (~acc_q[W-1:0] + 1'b1)   : acc_q[W-1:0];
            hi_d = rem_neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rs_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rs_q      <= rs_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It is the receiving end of the MULT/MULTU/DIV/DIVU/MTHI/MTLO requests decoded from R-type functcodes. It replaces single-cycle combinational HI/LO generation with a registered shift-add multiplier and restoring divider behind a valid/ready handshake. MFHI/MFLO read HI/LO directly; the pipeline stalls on `busy`.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width. Only 32 is supported; the iteration counter width is $clog2(DATA_WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state==IDLE)
- functcode  in  6  0x18 MULT, 0x19 MULTU, 0x1a DIV, 0x1b DIVU, 0x11 MTHI, 0x13 MTLO
- rs_content  in  32  operand A / dividend / MTHI-MTLO source
- rt_content  in  32  operand B / divisor
- cancel  in  1  synchronous abort (exception flush)
- busy  out  1  mul/div in flight (state != IDLE)
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=0, LO=0, done=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation.
- A request is accepted on a rising edge with req_valid && req_ready && !cancel. Operands are latched on that edge. The request source holds all inputs while req_ready=0.
- States:
  - IDLE: accept a request. MULT*/DIV* go to RUN with counter=0. MTHI writes HI=rs_content and MTLO writes LO=rs_content on the acceptance edge; these stay in IDLE and produce no done pulse. Any other functcode is accepted and ignored.
  - RUN: one iteration per cycle for 32 cycles (counter 0..31). Goes to FIX on the edge where counter==31.
  - FIX: applies sign correction, writes HI/LO, sets done=1, then goes to IDLE.
- Latency: request accepted at edge E0; RUN occupies edges E1..E32; E33 writes HI/LO and raises done. done clears at E34. The next request can be accepted at E34, giving a throughput of 1 per 34 cycles.
- Multiply:
  - Operate on magnitudes (MULT: |rs|, |rt|; MULTU: raw operands), radix-2 shift-add into a 64-bit product.
  - MULT negates the 64-bit product if the operand signs differ.
  - {HI,LO} = product.
- Divide:
  - Restoring division on magnitudes, 32 steps, one quotient bit per step.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - Divide by zero (rt==0, any signedness): LO=0xFFFFFFFF, HI=rs_content. Full latency is still taken.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- cancel:
  - In RUN or FIX: go to IDLE on the next edge. HI/LO are unchanged and no done pulse is produced.
  - In IDLE: blocks acceptance, so a simultaneous request is dropped, including MTHI/MTLO.
- HI/LO are written only in FIX, or on MTHI/MTLO acceptance. They are never written in the same cycle by both paths, because MT* is accepted only in IDLE.

Decomposition:
- Shared package mips_pkg:
  - functcode localparams (FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO)
  - state enum muldiv_state_t {IDLE, RUN, FIX}
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: op is-div flag, partial accumulator, operand registers.
  - Outputs: next accumulator and next quotient bit.
- The top module holds the FSM, counter, operand and HI/LO registers, and sign fix-up.

Test Plan:
1. MULT rs=0xFFFFFFFD, rt=0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. done high exactly 33 edges after acceptance; busy=1 and req_ready=0 throughout.
2. MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULTU 3×5 issued the cycle after done → accepted at E34, giving LO=0xF, HI=0.
3. DIV 0xFFFFFFF9 / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
4. DIV rs=5, rt=0 → LO=0xFFFFFFFF, HI=5 after full latency. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
5. In IDLE, MTHI rs=0x12345678 → HI=0x12345678 the next cycle, no done, busy stays 0. MTLO issued while a MULT is RUN → req_ready=0, request held, then accepted in the cycle after done.
6. Preload HI=0xA, LO=0xB; start MULT, assert cancel at RUN counter 10 → IDLE next cycle, HI/LO unchanged, no done. Repeat with rst_n low mid-RUN → HI=LO=0 immediately, state IDLE.
